// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect, decode handshake
// and the push counter.
//   master : fetch unit side (drives imem_pc, id_*, fetch_count)
//   slave  : environment side (drives fetch_en, imem_instr, redirect_*, id_ready)
interface instruction_fetch_unit_if;
  logic        fetch_en;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [31:0] fetch_count;

  modport master (
    input  fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    output imem_pc, id_valid, id_instr, id_pc, fetch_count
  );

  modport slave (
    output fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    input  imem_pc, id_valid, id_instr, id_pc, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: a word-aligned PC drives instruction memory, fetched
// {pc, instr} pairs go into a 2-entry buffer that decode drains via a
// valid/ready handshake. A redirect flushes the buffer and reloads the PC.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_en, imem_pc/imem_instr, redirect_valid/redirect_pc,
//           id_valid/id_ready/id_instr/id_pc, fetch_count
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_unit_if.master  bus
);

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned OCC_W   = 2;

  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:2], 2'b00};

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fb_entry_t;

  logic [PC_W-1:0]  pc_q,    pc_d;
  fb_entry_t        head_q,  head_d;
  fb_entry_t        tail_q,  tail_d;
  logic [OCC_W-1:0] occ_q,   occ_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] fetch_count_q;

  logic             pop_c;
  logic             push_c;
  logic [OCC_W-1:0] occ_pop_c;
  fb_entry_t        new_entry_c;

  // Handshake qualification; redirect voids both directions.
  assign pop_c       = valid_q & bus.id_ready & ~bus.redirect_valid;
  assign push_c      = bus.fetch_en & ~bus.redirect_valid &
                       ((occ_q != OCC_W'(2)) | pop_c);
  assign occ_pop_c   = occ_q - OCC_W'(pop_c);
  assign new_entry_c = '{pc: pc_q, instr: bus.imem_instr};

  // Next-state: pop shifts tail into head (head cleared when emptying so the
  // decode outputs read zero), then push writes the first free slot.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    count_d = count_q;
    if (bus.redirect_valid) begin
      pc_d   = {bus.redirect_pc[PC_W-1:2], 2'b00};
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (pop_c) begin
        head_d = (occ_q == OCC_W'(2)) ? tail_q : '0;
      end
      if (push_c) begin
        if (occ_pop_c == '0) head_d = new_entry_c;
        else                 tail_d = new_entry_c;
        pc_d    = pc_q + PC_W'(4);
        count_d = count_q + CNT_W'(1);
      end
      occ_d = occ_pop_c + OCC_W'(push_c);
    end
    valid_d = (occ_d != '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC_ALIGNED;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign fetch_count_q   = count_q;
  assign bus.imem_pc     = pc_q;
  assign bus.id_valid    = valid_q;
  assign bus.id_instr    = head_q.instr;
  assign bus.id_pc       = head_q.pc;
  assign bus.fetch_count = fetch_count_q;

endmodule
